// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------+
// | seg_pkg : shared 7-segment constants and scan state encoding         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  // Active-low patterns, bit7=a .. bit1=g, bit0=dp
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0001_1001;

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
// +----------------------------------------------------------------------+
// | seg_scan_ctrl_if : pattern/mask inputs and LED drive of the scanner  |
// | Optional macro: SEG_SCAN_DIM_EN adds bright[2:0].  Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic [DIGITS*8-1:0] seg_data;
  logic [DIGITS-1:0]   digit_mask;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]          bright;
`endif
  logic [DIGITS-1:0]   led_en;
  logic [7:0]          led_seg;
  logic                frame_tick;

`ifdef SEG_SCAN_DIM_EN
  modport master (output seg_data, digit_mask, bright, input led_en, led_seg, frame_tick);
  modport slave  (input seg_data, digit_mask, bright, output led_en, led_seg, frame_tick);
`else
  modport master (output seg_data, digit_mask, input led_en, led_seg, frame_tick);
  modport slave  (input seg_data, digit_mask, output led_en, led_seg, frame_tick);
`endif

endinterface

`default_nettype wire

// File: rtl/seg_scan_ctrl_next_sel.sv
// +----------------------------------------------------------------------+
// | seg_next_sel : wrap-around priority search for the next enabled digit|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seg_next_sel #(
  parameter int DIGITS = 8
) (
  input  logic [DIGITS-1:0]         mask,
  input  logic [$clog2(DIGITS)-1:0] idx,
  output logic [$clog2(DIGITS)-1:0] next,
  output logic                      valid
);

  localparam int IW = $clog2(DIGITS);

  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the nearest hit after idx wins; idx itself is tried last.
  always_comb begin
    next  = idx;
    valid = 1'b0;
    cand  = idx;
    for (int k = DIGITS; k >= 1; k--) begin
      cand = IW'((int'(idx) + k) % DIGITS);
      if (mask[cand]) begin
        next  = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | seg_scan_ctrl : multiplexed 7-seg scanner with inter-digit blanking  |
// | Optional macro: SEG_SCAN_DIM_EN (PWM dimming in SHOW).  Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 20000,
  parameter int BLANK_CYC = 100
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int IW       = $clog2(DIGITS);
  localparam int CW       = $clog2(SCAN_DIV);
  localparam int SHOW_LEN = SCAN_DIV - BLANK_CYC;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_LEN - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  scan_state_t       state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n, next;
  logic              valid;
  logic [7:0]        snap, snap_n, seg_q, seg_n;
  logic [DIGITS-1:0] en_q, en_n;
  logic              tick_q, tick_n, lit;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]        bright_q, bright_n;
`endif

  seg_next_sel #(.DIGITS(DIGITS)) u_next_sel (
    .mask  (bus.digit_mask),
    .idx   (idx),
    .next  (next),
    .valid (valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BLANK;
      cnt      <= '0;
      idx      <= IW'(DIGITS - 1);
      snap     <= SEG_BLANK;
      en_q     <= '1;
      seg_q    <= SEG_BLANK;
      tick_q   <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      bright_q <= 3'd7;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      snap     <= snap_n;
      en_q     <= en_n;
      seg_q    <= seg_n;
      tick_q   <= tick_n;
`ifdef SEG_SCAN_DIM_EN
      bright_q <= bright_n;
`endif
    end
  end

  // Outputs are computed from the next-state values so they register on the same edge as the FSM.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    snap_n   = snap;
    tick_n   = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    bright_n = bright_q;
`endif
    case (state)
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_n = '0;
          if (valid) begin
            state_n  = SHOW;
            idx_n    = next;
            snap_n   = bus.seg_data[{next, 3'b000} +: 8];
            tick_n   = (next <= idx);
`ifdef SEG_SCAN_DIM_EN
            bright_n = bus.bright;
`endif
          end
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = '0;
      end
    endcase

`ifdef SEG_SCAN_DIM_EN
    lit = (int'(cnt_n) < (((int'(bright_n) + 1) * SHOW_LEN) / 8));
`else
    lit = 1'b1;
`endif

    en_n  = '1;
    seg_n = SEG_BLANK;
    if (state_n == SHOW && lit) begin
      en_n[idx_n] = 1'b0;
      seg_n       = snap_n;
    end
  end

  assign bus.led_en     = en_q;
  assign bus.led_seg    = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_seg_scan_ctrl : scoreboard bench for seg_scan_ctrl (8/10/2 config)|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int DIGITS    = 8;
  localparam int SCAN_DIV  = 10;
  localparam int BLANK_CYC = 2;
  localparam int SHOW_LEN  = SCAN_DIV - BLANK_CYC;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] seg;
    logic       tick;
  } exp_t;

  logic clk;
  logic rst;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       q[$];
  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;
  logic [7:0] pat [8];

  task automatic push_off(input int n);
    exp_t e;
    e.en   = 8'hFF;
    e.seg  = SEG_BLANK;
    e.tick = 1'b0;
    repeat (n) q.push_back(e);
  endtask

  // One slot: SHOW_LEN cycles (first lit_cyc of them lit) followed by the blank gap.
  task automatic push_slot(input int d, input logic [7:0] seg, input logic tick, input int lit_cyc);
    exp_t e;
    for (int c = 0; c < SHOW_LEN; c++) begin
      e.tick = (c == 0) ? tick : 1'b0;
      if (c < lit_cyc) begin
        e.en  = ~(8'h01 << d);
        e.seg = seg;
      end else begin
        e.en  = 8'hFF;
        e.seg = SEG_BLANK;
      end
      q.push_back(e);
    end
    push_off(BLANK_CYC);
  endtask

  task automatic compare(input string tag);
    exp_t obs, exp;
    obs = {bus.led_en, bus.led_seg, bus.frame_tick};
    exp = (q.size() != 0) ? q.pop_front() : exp_t'('x);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed en=%h seg=%h tick=%b expected en=%h seg=%h tick=%b",
             tag, obs.en, obs.seg, obs.tick, exp.en, exp.seg, exp.tick);
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      compare(tag);
    end
  endtask

  task automatic set_digit(input int d, input logic [7:0] v);
    bus.seg_data[d*8 +: 8] = v;
  endtask

  initial begin
    pat = '{8'h9F, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8};
    for (int i = 0; i < DIGITS; i++) set_digit(i, pat[i]);
    bus.digit_mask = 8'hFF;
`ifdef SEG_SCAN_DIM_EN
    bus.bright = 3'd7;
`endif
    rst = 1'b1;

    @(negedge clk);
    push_off(1);
    compare("reset");

    // Release: one more blank cycle visible, then digit 0 (wrap from idx 7 ticks).
    rst = 1'b0;
    push_off(1);
    for (int s = 0; s < 20; s++) push_slot(s % 8, pat[s % 8], (s % 8) == 0, SHOW_LEN);
    run(201, "mask_ff");

    bus.digit_mask = 8'h03;
    for (int s = 0; s < 4; s++) push_slot(s % 2, pat[s % 2], (s % 2) == 0, SHOW_LEN);
    run(40, "mask_03");

    bus.digit_mask = 8'h01;
    for (int s = 0; s < 3; s++) push_slot(0, pat[0], 1'b1, SHOW_LEN);
    run(30, "mask_01");

    bus.digit_mask = 8'h00;
    push_off(20);
    run(20, "mask_00");

    bus.digit_mask = 8'h04;
    push_slot(2, pat[2], 1'b0, SHOW_LEN);
    run(10, "mask_04");

    bus.digit_mask = 8'h01;
    set_digit(0, 8'h03);
    push_slot(0, 8'h03, 1'b1, SHOW_LEN);
    push_slot(0, 8'h25, 1'b1, SHOW_LEN);
    run(3, "seg_hold");
    set_digit(0, 8'h25);
    run(17, "seg_hold");

    push_slot(0, 8'h25, 1'b1, SHOW_LEN);
    run(4, "pre_rst");
    #2 rst = 1'b1;
    #1;
    q.delete();
    push_off(1);
    compare("async_rst");
    q.delete();

    @(negedge clk);
    rst = 1'b0;
    push_off(1);
    push_slot(0, 8'h25, 1'b1, SHOW_LEN);
    run(11, "post_rst");

`ifdef SEG_SCAN_DIM_EN
    bus.bright = 3'd1;
    push_slot(0, 8'h25, 1'b1, 2);
    run(10, "dim_1");
    bus.bright = 3'd7;
    push_slot(0, 8'h25, 1'b1, SHOW_LEN);
    run(10, "dim_7");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
